phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 8, number of instruction phases per cycle (range 2..16).
REQ-002 Parameter WAIT_W, default 4, width of the per-phase wait-state count.
REQ-003 Parameter PH_W, default $clog2(NUM_PHASES), width of the binary phase index.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST_  in  1  asynchronous, active-low reset.
REQ-006 EN  in  1  sequencer enable, sampled in IDLE and at cycle wrap.
REQ-007 HOLD  in  1  stall; freezes all registered state while high.
REQ-008 WAIT_CNT  in  WAIT_W  extra cycles for the current phase, sampled in the phase's first cycle.
REQ-009 RESTART  in  1  short instruction; on an advance cycle it forces a wrap to phase 0.
REQ-010 IRQ  in  1  interrupt request, level.
REQ-011 PHASE  out  PH_W  current phase index.
REQ-012 PHASE_OH  out  NUM_PHASES  one-hot copy of PHASE.
REQ-013 PH_START  out  1  high in the first cycle of a phase.
REQ-014 PH_ADV  out  1  high in the cycle the phase advances.
REQ-015 CYCLE_END  out  1  high in the advance cycle that wraps to phase 0.
REQ-016 BUSY  out  1  high when state is not IDLE.
REQ-017 IRQ_ACK  out  1  one-cycle interrupt acknowledge.

Function
REQ-018 The states SHALL be IDLE, ACTIVE and HELD; HELD is entered from ACTIVE when HOLD=1 and returns to ACTIVE when HOLD=0.
REQ-019 IDLE with EN=1 SHALL enter ACTIVE at phase 0 on the next edge, with PH_START=1 in that first cycle.
REQ-020 Each phase SHALL last 1+WAIT_CNT non-held cycles; WAIT_CNT=0 gives a single-cycle phase.
REQ-021 A wait down-counter SHALL load WAIT_CNT in the PH_START cycle and decrement on each non-held cycle.
REQ-022 PH_ADV SHALL be high when the counter is 0 and HOLD=0; it is combinational from state and HOLD.
REQ-023 On PH_ADV, PHASE SHALL go to PHASE+1, or to 0 when PHASE=NUM_PHASES-1 or RESTART=1; CYCLE_END=PH_ADV on that wrap.
REQ-024 At a wrap, EN=0 SHALL return the sequencer to IDLE at phase 0; EN=1 SHALL start phase 0 directly, with no idle cycle.
REQ-025 EN falling mid-cycle SHALL be ignored until the next wrap.
REQ-026 While HOLD=1, PHASE, the counter, PH_START and the state register SHALL be frozen; PH_ADV and CYCLE_END SHALL be 0.
REQ-027 PH_START SHALL remain high throughout a HOLD that extends a phase's first cycle.
REQ-028 RESTART SHALL be ignored outside advance cycles; RESTART in phase NUM_PHASES-1 is equivalent to a normal wrap.
REQ-029 PHASE_OH SHALL always equal 1<<PHASE, including in IDLE.

Reset
REQ-030 RST_=0 SHALL asynchronously force state IDLE, PHASE=0, PHASE_OH=1, counter=0, and PH_START, PH_ADV, CYCLE_END, BUSY and IRQ_ACK to 0.
REQ-031 Reset asserted mid-phase SHALL discard the pending wait count and any pending IRQ.
REQ-032 The first rising edge after RST_ deasserts SHALL evaluate EN from IDLE.

Configuration
REQ-033 Macro PHASE_SEQ_IRQ_EN: when defined, IRQ=1 sampled in a CYCLE_END cycle with EN=1 SHALL assert IRQ_ACK for the next (phase-0) cycle, and the sequencer SHALL stay in IDLE-equivalent hold for that one cycle before PH_START.
REQ-034 Without PHASE_SEQ_IRQ_EN, IRQ SHALL be ignored and IRQ_ACK SHALL be tied 0; the ports remain present.

Verification
REQ-035 Default parameters, EN=1, WAIT_CNT=0 -> PHASE steps 0..7, with CYCLE_END high in the phase-7 cycle and phase 0 the next cycle.
REQ-036 WAIT_CNT=2 in phase 3 -> phase 3 lasts 3 cycles; PH_START high only in the first, PH_ADV only in the third.
REQ-037 HOLD=1 for 4 cycles in phase 5 -> PHASE stays 5, no PH_ADV; the phase resumes with its remaining wait count intact.
REQ-038 RESTART=1 on the advance cycle of phase 2 -> next PHASE=0 with CYCLE_END=1; EN=0 at that wrap -> IDLE, BUSY=0.
REQ-039 RST_ low in phase 4, asynchronous to CLK -> outputs reach their reset values immediately, without waiting for a clock edge.
REQ-040 With PHASE_SEQ_IRQ_EN defined, IRQ=1 at CYCLE_END -> IRQ_ACK pulses for 1 cycle, then PH_START at phase 0; without the macro -> IRQ_ACK stays 0.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: per-phase wait-state sequencer with hold, restart and optional interrupt slot (PHASE_SEQ_IRQ_EN)
module phase_sequencer #(
  parameter int NUM_PHASES = 8,
  parameter int WAIT_W = 4,
  parameter int PH_W = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  hold,
  input  logic [WAIT_W-1:0]     wait_cnt,
  input  logic                  restart,
  input  logic                  irq,
  output logic [PH_W-1:0]       phase,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic                  ph_start,
  output logic                  ph_adv,
  output logic                  cycle_end,
  output logic                  busy,
  output logic                  irq_ack
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HELD} state_t;
  state_t state;
  logic [WAIT_W-1:0] cnt, cur;
  logic run, wrap, irq_take;
`ifdef PHASE_SEQ_IRQ_EN
  assign irq_take = cycle_end && en && irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take = 1'b0;
`endif
  // The first cycle of a phase sees WAIT_CNT live, later cycles the loaded counter
  always_comb begin
    run = state != IDLE && !hold;
    cur = ph_start ? wait_cnt : cnt;
    ph_adv = run && cur == '0;
    wrap = restart || phase == PH_W'(NUM_PHASES - 1);
    cycle_end = ph_adv && wrap;
    busy = state != IDLE;
    phase_oh = NUM_PHASES'(1) << phase;
  end
  // Sequencer state; hold freezes everything, an acked interrupt spends one idle cycle before phase 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      ph_start <= 1'b0;
      irq_ack <= 1'b0;
    end else if (hold) begin
      if (state == ACTIVE) state <= HELD;
    end else if (state == IDLE) begin
      irq_ack <= 1'b0;
      if (irq_ack || en) begin
        state <= ACTIVE;
        ph_start <= 1'b1;
        cnt <= '0;
      end
    end else begin
      state <= ACTIVE;
      ph_start <= ph_adv;
      cnt <= ph_adv ? '0 : cur - 1'b1;
      if (ph_adv) phase <= wrap ? '0 : phase + 1'b1;
      if (cycle_end && (!en || irq_take)) begin
        state <= IDLE;
        ph_start <= 1'b0;
        irq_ack <= irq_take;
      end
    end
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed table-driven checks of phase_sequencer plus reset and interrupt sequences
module tb_phase_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, hold = 1'b0, restart = 1'b0, irq = 1'b0;
  logic [3:0] wait_cnt = '0;
  logic [2:0] phase;
  logic [7:0] phase_oh;
  logic ph_start, ph_adv, cycle_end, busy, irq_ack;
  int checks = 0, failures = 0;

  phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .wait_cnt(wait_cnt),
    .restart(restart), .irq(irq), .phase(phase), .phase_oh(phase_oh),
    .ph_start(ph_start), .ph_adv(ph_adv), .cycle_end(cycle_end),
    .busy(busy), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, hold;
    logic [3:0] wc;
    logic rs;
    logic [2:0] ph;
    logic st, adv, ce, bz;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ph, input int st, input int adv,
                         input int ce, input int bz, input int ack);
    logic [7:0] oh;
    oh = 8'(1) << ph;
    chk({tag, ".phase"}, int'(phase), ph);
    chk({tag, ".phase_oh"}, int'(phase_oh), int'(oh));
    chk({tag, ".ph_start"}, int'(ph_start), st);
    chk({tag, ".ph_adv"}, int'(ph_adv), adv);
    chk({tag, ".cycle_end"}, int'(cycle_end), ce);
    chk({tag, ".busy"}, int'(busy), bz);
    chk({tag, ".irq_ack"}, int'(irq_ack), ack);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv.push_back('{0,0,0,0, 0,0,0,0,0});
    tv.push_back('{1,0,0,0, 0,0,0,0,0});
    tv.push_back('{1,0,0,0, 0,1,1,0,1});
    tv.push_back('{1,0,0,0, 1,1,1,0,1});
    tv.push_back('{1,0,0,0, 2,1,1,0,1});
    tv.push_back('{1,0,2,0, 3,1,0,0,1});
    tv.push_back('{1,0,0,0, 3,0,0,0,1});
    tv.push_back('{1,0,0,0, 3,0,1,0,1});
    tv.push_back('{1,0,0,0, 4,1,1,0,1});
    tv.push_back('{1,0,2,0, 5,1,0,0,1});
    for (int i = 0; i < 4; i++) tv.push_back('{1,1,0,0, 5,0,0,0,1});
    tv.push_back('{1,0,0,0, 5,0,0,0,1});
    tv.push_back('{1,0,0,0, 5,0,1,0,1});
    tv.push_back('{1,0,0,0, 6,1,1,0,1});
    tv.push_back('{1,0,0,0, 7,1,1,1,1});
    tv.push_back('{1,0,0,0, 0,1,1,0,1});
    tv.push_back('{1,0,0,0, 1,1,1,0,1});
    tv.push_back('{0,0,0,1, 2,1,1,1,1});
    tv.push_back('{0,0,0,0, 0,0,0,0,0});
    tv.push_back('{0,0,0,1, 0,0,0,0,0});
    tv.push_back('{1,0,0,0, 0,0,0,0,0});
    tv.push_back('{1,1,0,0, 0,1,0,0,1});
    tv.push_back('{1,1,0,0, 0,1,0,0,1});
    tv.push_back('{1,0,1,1, 0,1,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,1,0,1});
    tv.push_back('{0,0,0,0, 1,1,1,0,1});
    for (int p = 2; p < 7; p++) tv.push_back('{0,0,0,0, 3'(p),1,1,0,1});
    tv.push_back('{0,0,0,0, 7,1,1,1,1});
    tv.push_back('{0,0,0,0, 0,0,0,0,0});

    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    foreach (tv[i]) begin
      en = tv[i].en;
      hold = tv[i].hold;
      wait_cnt = tv[i].wc;
      restart = tv[i].rs;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tv[i].ph, tv[i].st, tv[i].adv, tv[i].ce, tv[i].bz, 0);
      step();
    end

    en = 1'b1;
    wait_cnt = 4'd0;
    repeat (5) step();
    wait_cnt = 4'd3;
    @(negedge clk);
    chk_all("pre_rst", 4, 1, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt = 4'd0;
    step();
    @(negedge clk);
    chk_all("post_rst", 0, 1, 1, 0, 1, 0);

    step();
    irq = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk_all("irq_wrap", 7, 1, 1, 1, 1, 0);
    step();
    irq = 1'b0;
    @(negedge clk);
`ifdef PHASE_SEQ_IRQ_EN
    chk_all("irq_ack", 0, 0, 0, 0, 0, 1);
    step();
    @(negedge clk);
    chk_all("irq_after", 0, 1, 1, 0, 1, 0);
`else
    chk_all("irq_ignored", 0, 1, 1, 0, 1, 0);
    step();
    @(negedge clk);
    chk_all("irq_after", 1, 1, 1, 0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
